// File: rtl/debug_1bit_monitor_if.sv
// Heartbeat monitor port bundle: observed line and clear in, status and statistics out.
// The monitor takes the slave side, the observer or host takes the master side.
interface debug_1bit_monitor_if #(
  parameter int GAP_W = 8,
  parameter int CNT_W = 16
) ();
  logic             bit_in;
  logic             clr;
  logic             edge_pulse;
  logic             alive;
  logic             stall;
  logic             stall_sticky;
  logic [CNT_W-1:0] edge_cnt;
  logic [GAP_W-1:0] last_gap;

  modport master (
    output bit_in, clr,
    input  edge_pulse, alive, stall, stall_sticky, edge_cnt, last_gap
  );

  modport slave (
    input  bit_in, clr,
    output edge_pulse, alive, stall, stall_sticky, edge_cnt, last_gap
  );
endinterface

// File: rtl/debug_1bit_monitor.sv
// Liveness checker for a toggling 1-bit heartbeat: edge count, inter-edge gap, stall flag.
// Define DEBUG_1BIT_MONITOR_SYNC_EN to put a two-flop synchronizer in front of bit_in.
//
// state | meaning
// IDLE  | waiting for the first (arming) edge after reset
// RUN   | edges arriving within TIMEOUT cycles
// STALL | no edge for TIMEOUT cycles; left on the next edge
module debug_1bit_monitor #(
  parameter int TIMEOUT = 16,
  parameter int GAP_W   = 8,
  parameter int CNT_W   = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  debug_1bit_monitor_if.slave mon
);

  typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

  localparam logic [GAP_W-1:0] GAP_MAX   = '1;
  localparam logic [GAP_W-1:0] TIMEOUT_V = GAP_W'(TIMEOUT);

  state_t           state, state_nxt;
  logic             s2, prv, pulse;
  logic [GAP_W-1:0] gap_cnt;
  logic [CNT_W-1:0] edge_cnt, edge_cnt_nxt;
  logic [GAP_W-1:0] last_gap, last_gap_nxt;
  logic             sticky, sticky_nxt;
  logic             stall_entry;

`ifdef DEBUG_1BIT_MONITOR_SYNC_EN
  logic s1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= mon.bit_in;
      s2 <= s1;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) s2 <= 1'b0;
    else        s2 <= mon.bit_in;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prv   <= 1'b0;
      pulse <= 1'b0;
    end else begin
      prv   <= s2;
      pulse <= s2 ^ prv;
    end
  end

  // Gap counter restarts at 1 so last_gap equals the toggle period in cycles.
  always_ff @(posedge clk) begin
    if (!rst_n)                gap_cnt <= '0;
    else if (pulse)            gap_cnt <= GAP_W'(1);
    else if (gap_cnt != GAP_MAX) gap_cnt <= gap_cnt + GAP_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      edge_cnt <= '0;
      last_gap <= '0;
      sticky   <= 1'b0;
    end else begin
      state    <= state_nxt;
      edge_cnt <= edge_cnt_nxt;
      last_gap <= last_gap_nxt;
      sticky   <= sticky_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    edge_cnt_nxt = edge_cnt;
    last_gap_nxt = last_gap;
    sticky_nxt   = sticky;
    stall_entry  = 1'b0;
    case (state)
      IDLE: begin
        if (pulse) begin
          state_nxt    = RUN;
          edge_cnt_nxt = edge_cnt + CNT_W'(1);
        end
      end
      RUN: begin
        if (pulse) begin
          last_gap_nxt = gap_cnt;
          edge_cnt_nxt = edge_cnt + CNT_W'(1);
        end else if (gap_cnt == TIMEOUT_V) begin
          state_nxt   = STALL;
          stall_entry = 1'b1;
        end
      end
      STALL: begin
        if (pulse) begin
          state_nxt    = RUN;
          last_gap_nxt = gap_cnt;
          edge_cnt_nxt = edge_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Clear beats edge updates for the statistics, but a stall entry still sets the sticky flag.
    if (mon.clr) begin
      edge_cnt_nxt = '0;
      last_gap_nxt = '0;
      sticky_nxt   = 1'b0;
    end
    if (stall_entry) sticky_nxt = 1'b1;
  end

  assign mon.edge_pulse   = pulse;
  assign mon.alive        = (state == RUN);
  assign mon.stall        = (state == STALL);
  assign mon.stall_sticky = sticky;
  assign mon.edge_cnt     = edge_cnt;
  assign mon.last_gap     = last_gap;

endmodule

// File: tb/tb_debug_1bit_monitor.sv
// Bench for debug_1bit_monitor: a per-cycle vector table from reset, then directed
// sequences for fast toggling, slow toggling, timeout, saturation and reset from STALL.
module tb_debug_1bit_monitor;
  localparam int TIMEOUT = 16;
  localparam int GAP_W   = 8;
  localparam int CNT_W   = 16;
`ifdef DEBUG_1BIT_MONITOR_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam int NV = 15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  debug_1bit_monitor_if #(.GAP_W(GAP_W), .CNT_W(CNT_W)) mon ();

  debug_1bit_monitor #(.TIMEOUT(TIMEOUT), .GAP_W(GAP_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mon   (mon)
  );

  typedef struct {
    logic rst_n, bit_in, clr;
    logic pulse, alive, stall, sticky;
    int   cnt, gap;
  } vec_t;

  vec_t vt [NV];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    total++;
    if (act !== 32'(exp)) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic b, input logic c, input logic p,
                              input logic a, input logic s, input logic k, input int n,
                              input int g);
    vec_t v;
    v.rst_n = r; v.bit_in = b; v.clr = c;
    v.pulse = p; v.alive = a; v.stall = s; v.sticky = k;
    v.cnt = n; v.gap = g;
    return v;
  endfunction

  task automatic wait_pulse(input string name, input int lim);
    bit found = 1'b0;
    for (int i = 0; i < lim && !found; i++) begin
      @(negedge clk);
      if (mon.edge_pulse === 1'b1) found = 1'b1;
    end
    check(name, 32'(found), 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mon.bit_in = 1'b0;
    mon.clr = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    bit hit;
    rst_n = 1'b0;
    mon.bit_in = 1'b0;
    mon.clr = 1'b0;

    //            rst bit clr | pulse alive stall sticky cnt gap
    vt[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[2]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0);
    vt[3]  = mk(1, 0, 0, 1, 0, 0, 0, 0, 0);
    vt[4]  = mk(1, 1, 0, 1, 1, 0, 0, 1, 0);
    vt[5]  = mk(1, 1, 0, 1, 1, 0, 0, 2, 1);
    vt[6]  = mk(1, 1, 0, 0, 1, 0, 0, 3, 1);
    vt[7]  = mk(1, 1, 0, 0, 1, 0, 0, 3, 1);
    vt[8]  = mk(1, 0, 1, 0, 1, 0, 0, 0, 0);
    vt[9]  = mk(1, 0, 0, 1, 1, 0, 0, 0, 0);
    vt[10] = mk(1, 0, 1, 0, 1, 0, 0, 0, 0);
    vt[11] = mk(1, 1, 0, 0, 1, 0, 0, 0, 0);
    vt[12] = mk(1, 1, 0, 1, 1, 0, 0, 0, 0);
    vt[13] = mk(1, 1, 0, 0, 1, 0, 0, 1, 3);
    vt[14] = mk(1, 1, 0, 0, 1, 0, 0, 1, 3);

    @(negedge clk);
    // bit_in is fed LAT-2 rows early so the synchronizer's extra stage lines up with the table
    for (int i = 0; i < NV; i++) begin
      rst_n      = vt[i].rst_n;
      mon.bit_in = vt[(i + LAT - 2 < NV) ? i + LAT - 2 : NV - 1].bit_in;
      mon.clr    = vt[i].clr;
      @(negedge clk);
      check($sformatf("vec%0d.pulse", i),  32'(mon.edge_pulse),   int'(vt[i].pulse));
      check($sformatf("vec%0d.alive", i),  32'(mon.alive),        int'(vt[i].alive));
      check($sformatf("vec%0d.stall", i),  32'(mon.stall),        int'(vt[i].stall));
      check($sformatf("vec%0d.sticky", i), 32'(mon.stall_sticky), int'(vt[i].sticky));
      check($sformatf("vec%0d.cnt", i),    32'(mon.edge_cnt),     vt[i].cnt);
      check($sformatf("vec%0d.gap", i),    32'(mon.last_gap),     vt[i].gap);
    end
    mon.clr = 1'b0;

    // Toggle every clock for 20 cycles
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      mon.bit_in = ~mon.bit_in;
      @(negedge clk);
    end
    repeat (LAT) @(negedge clk);
    check("fast.alive", 32'(mon.alive), 1);
    check("fast.stall", 32'(mon.stall), 0);
    check("fast.cnt",   32'(mon.edge_cnt), 20);
    check("fast.gap",   32'(mon.last_gap), 1);

    // Toggle every 5 cycles
    for (int k = 0; k < 8; k++) begin
      mon.bit_in = ~mon.bit_in;
      repeat (5) @(negedge clk);
      if (k >= 1) begin
        check($sformatf("slow%0d.gap", k),    32'(mon.last_gap), 5);
        check($sformatf("slow%0d.sticky", k), 32'(mon.stall_sticky), 0);
      end
    end
    check("slow.cnt", 32'(mon.edge_cnt), 28);

    // Stop toggling: stall rises TIMEOUT+1 cycles after the last pulse
    mon.bit_in = ~mon.bit_in;
    wait_pulse("last_pulse_seen", 10);
    n = 0;
    hit = 1'b0;
    while (n < 60 && !hit) begin
      @(negedge clk);
      n++;
      if (mon.stall === 1'b1) hit = 1'b1;
    end
    check("timeout.delay",  32'(n), TIMEOUT + 1);
    check("timeout.alive",  32'(mon.alive), 0);
    check("timeout.sticky", 32'(mon.stall_sticky), 1);

    // Resume after a long silence: gap saturates
    repeat (300) @(negedge clk);
    check("long.stall_held", 32'(mon.stall), 1);
    mon.bit_in = ~mon.bit_in;
    wait_pulse("resume_pulse_seen", 10);
    @(negedge clk);
    check("resume.alive",  32'(mon.alive), 1);
    check("resume.stall",  32'(mon.stall), 0);
    check("resume.gap",    32'(mon.last_gap), 255);
    check("resume.sticky", 32'(mon.stall_sticky), 1);
    check("resume.cnt",    32'(mon.edge_cnt), 30);
    mon.clr = 1'b1;
    @(negedge clk);
    mon.clr = 1'b0;
    check("clr.sticky", 32'(mon.stall_sticky), 0);
    check("clr.cnt",    32'(mon.edge_cnt), 0);
    check("clr.alive",  32'(mon.alive), 1);

    // Reset from STALL with 37 edges counted, bit_in held high through release
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 37; i++) begin
      mon.bit_in = ~mon.bit_in;
      @(negedge clk);
    end
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(negedge clk);
      if (mon.stall === 1'b1) hit = 1'b1;
    end
    check("pre_rst.stall", 32'(hit), 1);
    check("pre_rst.cnt",   32'(mon.edge_cnt), 37);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst.pulse",  32'(mon.edge_pulse), 0);
    check("rst.alive",  32'(mon.alive), 0);
    check("rst.stall",  32'(mon.stall), 0);
    check("rst.sticky", 32'(mon.stall_sticky), 0);
    check("rst.cnt",    32'(mon.edge_cnt), 0);
    check("rst.gap",    32'(mon.last_gap), 0);
    rst_n = 1'b1;
    wait_pulse("arm_pulse_seen", 10);
    @(negedge clk);
    check("arm.alive", 32'(mon.alive), 1);
    check("arm.cnt",   32'(mon.edge_cnt), 1);
    check("arm.gap",   32'(mon.last_gap), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
